// File: rtl/regfile_wb_arb.sv
// Writeback arbiter for the 64-bit, 32-entry register file write port.
// ALU has priority; loads are queued and preempt the ALU after waiting.
module regfile_wb_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [63:0]              alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [63:0]              ld_data,
    output logic                     we,
    output logic [4:0]               Rw,
    output logic [63:0]              W,
    input  logic [4:0]               query_rd,
    output logic                     query_hit,
    output logic [$clog2(DEPTH):0]   ld_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [63:0]   fifo_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] wait_cnt;

    logic          fifo_nonempty;
    logic          starve;
    logic          alu_grant;
    logic          push;
    logic          pop;
    logic          any_grant;
    logic [4:0]    grant_rd;
    logic [63:0]   grant_data;

    // Handshakes and grant selection, from registered state plus requests.
    always_comb begin
        fifo_nonempty = (ld_pending != '0);
        starve        = fifo_nonempty && (wait_cnt == CW'(STARVE_MAX));
        alu_ready     = !starve;
        ld_ready      = (ld_pending != PW'(DEPTH));
        alu_grant     = alu_valid && alu_ready;
        pop           = !alu_grant && fifo_nonempty;
        push          = ld_valid && ld_ready;
        any_grant     = alu_grant || pop;
        grant_rd      = '0;
        grant_data    = '0;
        unique case (1'b1)
            alu_grant: begin
                grant_rd   = alu_rd;
                grant_data = alu_data;
            end
            pop: begin
                grant_rd   = fifo_rd[head];
                grant_data = fifo_data[head];
            end
            default: ;
        endcase
    end

    // Load queue storage; contents need no reset, validity is in ld_pending.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= ld_rd;
            fifo_data[tail] <= ld_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            ld_pending <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   ld_pending <= ld_pending + 1'b1;
                2'b01:   ld_pending <= ld_pending - 1'b1;
                default: ;
            endcase
        end
    end

    // Count how long a waiting queue head has been passed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!fifo_nonempty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(STARVE_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered write port; x0 grants are consumed but never write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            Rw <= '0;
            W  <= '0;
        end else if (any_grant) begin
            we <= (grant_rd != '0);
            Rw <= grant_rd;
            W  <= grant_data;
        end else begin
            we <= 1'b0;
        end
    end

    // Pending-write lookup across queue, output register and ALU grant.
    always_comb begin : query_cmp
        logic          hit;
        logic [AW-1:0] off;
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head;
            if (({1'b0, off} < ld_pending) && (fifo_rd[i] == query_rd))
                hit = 1'b1;
        end
        if (we && (Rw == query_rd))
            hit = 1'b1;
        if (alu_grant && (alu_rd == query_rd))
            hit = 1'b1;
        query_hit = hit && (query_rd != '0);
    end

endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Writeback-side driver for the 64-bit, 32-entry register file's single write port (we/Rw/W).
- Merges two producers into one registered write per cycle:
  - the ALU, which has priority and a ready signal;
  - the load unit, which is buffered in a small FIFO.
- Guarantees loads cannot starve, drops writes to x0, and provides a pending-write query for decode-stage hazard stalls.

Parameters:
- DEPTH, 4, load FIFO entries; power of 2, at least 2.
- STARVE_MAX, 3, consecutive cycles a non-empty FIFO head may wait before it preempts the ALU; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- ld_valid  in  1  load writeback request.
- ld_ready  out  1  load FIFO can accept this cycle.
- ld_rd  in  5  load destination register.
- ld_data  in  64  load data.
- we  out  1  register file write enable (registered).
- Rw  out  5  register file write address (registered).
- W  out  64  register file write data (registered).
- query_rd  in  5  register index to check for pending writes.
- query_hit  out  1  query_rd has a write in flight (combinational).
- ld_pending  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): on a rising clk edge with rst=1:
  - we=0, Rw=0, W=0;
  - FIFO emptied, ld_pending=0, wait counter=0;
  - takes effect even mid-operation; all queued loads are discarded.
- During reset cycles alu_ready and ld_ready are don't-care; upstream must not rely on acceptance while rst=1.

FIFO and load path:
- ld_ready = (ld_pending != DEPTH).
  - Based on registered occupancy only; a full FIFO refuses a push even when it pops in the same cycle.
- Push when ld_valid && ld_ready; stores {ld_rd, ld_data} at the tail.
- A load never writes the register file in the cycle it is pushed; minimum load latency is push edge + 1 cycle grant + 1 cycle to we.
- ld_pending is updated every edge: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Pointers wrap modulo DEPTH.

Starvation control:
- wait_cnt is a saturating counter, 0..STARVE_MAX.
  - Cleared when the FIFO is empty or a pop occurs.
  - Otherwise incremented, saturating.
- starve = (ld_pending != 0) && (wait_cnt == STARVE_MAX).
- alu_ready = !starve. This is combinational, from registered state only; no dependency on alu_valid.

Grant, one per cycle:
- If alu_valid && alu_ready: grant ALU.
- Else if ld_pending != 0: grant FIFO head (pop).
- Else: no grant.

Output register (next edge):
- On a grant: Rw<=grant_rd, W<=grant_data, we<=(grant_rd != 0).
- On no grant: we<=0; Rw and W hold their values.
- A grant with rd=0 is fully consumed (ALU accepted or FIFO popped) but produces we=0.
- ALU-to-write latency is exactly 1 cycle.

query_hit is 1 iff query_rd != 0 and any of the following:
- a valid FIFO entry has rd == query_rd;
- we=1 and Rw == query_rd;
- alu_valid && alu_ready && alu_rd == query_rd.

A same-cycle load push is not visible to query_hit until the next cycle.

Ordering:
- Loads are written in FIFO order.
- ALU and load writes to the same rd are written in grant order; upstream owns WAW ordering across the two sources.

Test Plan:
- Reset then idle: assert rst 2 cycles -> we=0, Rw=0, W=0, ld_pending=0, ld_ready=1, alu_ready=1; idle 5 cycles -> we stays 0.
- ALU-only: alu_valid with rd=5, data=0xDEAD_BEEF_0000_0001 -> next cycle we=1, Rw=5, W=that value; next cycle with no request -> we=0, Rw=5 held.
- x0 drop: ALU rd=0, data=0x1234, then load rd=0 -> both accepted (alu_ready=1, ld_pending returns to 0), we never asserts.
- FIFO fill and backpressure (DEPTH=4):
  - Setup: ALU asserting rd=1 every cycle; 5 loads rd=10..14 offered back-to-back.
  - Required: loads 10..13 accepted, ld_ready=0 with ld_pending=4, load 14 held until a pop frees space.
  - Required: loads written in order 10, 11, 12, 13, 14.
- Starvation (STARVE_MAX=3):
  - Setup: ALU continuously valid, one load queued.
  - Required: ALU writes for 3 cycles, then alu_ready=0 for 1 cycle, then the load writes (we=1, Rw=load rd), then alu_ready=1 again.
- Hazard query and reset mid-op:
  - Setup: load rd=7 queued; query_rd=7.
  - Required: query_hit=1 until the cycle after its we pulse; query_rd=0 -> query_hit=0.
  - Setup: rst asserted with 3 loads pending.
  - Required: next cycle ld_pending=0, we=0, and no queued load is ever written.
